// File: rtl/DPE_params.sv
// Shared DPE parameter set: MAC array geometry plus the LIF neuron field widths.
package DPE_params;
    localparam int unsigned DPE_OUTPUT_VEC_LEN = 4;
    localparam int unsigned DPE_WIDTH          = 8;
    localparam int unsigned DPE_REFRAC_W       = 4;
    localparam int unsigned DPE_LEAK_W         = 3;
    localparam int unsigned DPE_STEP_W         = 16;
endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane, refractory counter and the
// leak/integrate/saturate/threshold datapath for a single MAC lane.
module lif_neuron
    import DPE_params::*;
#(
    parameter int unsigned WIDTH    = DPE_WIDTH,
    parameter int unsigned REFRAC_W = DPE_REFRAC_W,
    parameter int unsigned LEAK_W   = DPE_LEAK_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    accept,
    input  logic        [WIDTH-1:0] current,
    input  logic signed [WIDTH-1:0] threshold,
    input  logic       [LEAK_W-1:0] leak_shift,
    input  logic     [REFRAC_W-1:0] refrac_cycles,
    output logic                    spike_c
);

    localparam int unsigned EXT_W = WIDTH + 2;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(64'sd1 <<< (WIDTH - 1)));

    logic signed    [WIDTH-1:0] v;
    logic        [REFRAC_W-1:0] refrac;
    logic signed    [EXT_W-1:0] v_ext;
    logic signed    [EXT_W-1:0] leak_ext;
    logic signed    [EXT_W-1:0] cur_ext;
    logic signed    [EXT_W-1:0] sum_ext;
    logic signed    [WIDTH-1:0] v_sat;

    // Leak shift of zero means no leak rather than a full discharge.
    always_comb begin
        v_ext    = EXT_W'(v);
        leak_ext = '0;
        if (leak_shift != '0) begin
            leak_ext = EXT_W'(v >>> leak_shift);
        end
        cur_ext = EXT_W'($signed(current));
        sum_ext = v_ext - leak_ext + cur_ext;
        if (sum_ext > SAT_MAX) begin
            v_sat = WIDTH'(SAT_MAX);
        end else if (sum_ext < SAT_MIN) begin
            v_sat = WIDTH'(SAT_MIN);
        end else begin
            v_sat = WIDTH'(sum_ext);
        end
        spike_c = (refrac == '0) && (v_sat >= threshold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v      <= '0;
            refrac <= '0;
        end else if (clear) begin
            v      <= '0;
            refrac <= '0;
        end else if (accept) begin
            if (refrac != '0) begin
                refrac <= refrac - REFRAC_W'(1);
                v      <= '0;
            end else if (spike_c) begin
                refrac <= refrac_cycles;
                v      <= '0;
            end else begin
                v      <= v_sat;
            end
        end
    end

endmodule

// File: rtl/lif_spike_gen.sv
// LIF spike generator: valid/ready handshake around an array of lif_neuron
// lanes, with a registered spike vector and a timestep counter.
module lif_spike_gen
    import DPE_params::*;
#(
    parameter int unsigned OUTPUT_VEC_LEN = DPE_OUTPUT_VEC_LEN,
    parameter int unsigned WIDTH          = DPE_WIDTH,
    parameter int unsigned REFRAC_W       = DPE_REFRAC_W,
    parameter int unsigned LEAK_W         = DPE_LEAK_W
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [OUTPUT_VEC_LEN-1:0][WIDTH-1:0]     currents,
    input  logic signed              [WIDTH-1:0]     threshold,
    input  logic                     [LEAK_W-1:0]    leak_shift,
    input  logic                     [REFRAC_W-1:0]  refrac_cycles,
    input  logic                                     clear,
    output logic [OUTPUT_VEC_LEN-1:0]                spikes,
    output logic                                     spikes_valid,
    input  logic                                     spikes_ready,
    output logic [DPE_STEP_W-1:0]                    step_count
);

    logic                      accept;
    logic [OUTPUT_VEC_LEN-1:0] spike_next;

    // Clear forces ready high but drops any same-cycle input.
    assign in_ready = ~spikes_valid | spikes_ready | clear;
    assign accept   = in_valid & in_ready & ~clear;

    for (genvar i = 0; i < int'(OUTPUT_VEC_LEN); i++) begin : g_neuron
        lif_neuron #(
            .WIDTH    (WIDTH),
            .REFRAC_W (REFRAC_W),
            .LEAK_W   (LEAK_W)
        ) u_neuron (
            .clk           (clk),
            .rst_n         (rst_n),
            .clear         (clear),
            .accept        (accept),
            .current       (currents[i]),
            .threshold     (threshold),
            .leak_shift    (leak_shift),
            .refrac_cycles (refrac_cycles),
            .spike_c       (spike_next[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spikes       <= '0;
            spikes_valid <= 1'b0;
            step_count   <= '0;
        end else if (clear) begin
            spikes       <= '0;
            spikes_valid <= 1'b0;
            step_count   <= '0;
        end else if (accept) begin
            spikes       <= spike_next;
            spikes_valid <= 1'b1;
            step_count   <= step_count + DPE_STEP_W'(1);
        end else if (spikes_ready) begin
            spikes_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lif_spike_gen.sv
// Self-checking bench for lif_spike_gen: directed scenarios plus random
// traffic, compared against an integer-arithmetic neuron/handshake model.
module tb_lif_spike_gen;

    localparam int N = 4;
    localparam int W = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0][W-1:0] currents;
    logic signed [W-1:0] threshold;
    logic [2:0]          leak_shift;
    logic [3:0]          refrac_cycles;
    logic                clear;
    logic [N-1:0]        spikes;
    logic                spikes_valid;
    logic                spikes_ready;
    logic [15:0]         step_count;

    always #5 clk = ~clk;

    lif_spike_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .currents      (currents),
        .threshold     (threshold),
        .leak_shift    (leak_shift),
        .refrac_cycles (refrac_cycles),
        .clear         (clear),
        .spikes        (spikes),
        .spikes_valid  (spikes_valid),
        .spikes_ready  (spikes_ready),
        .step_count    (step_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: plain integers per neuron.
    int       mv[N];
    int       mr[N];
    int       cur[N];
    logic [N-1:0] msp;
    bit       mvalid;
    int       mstep;
    int       thr, ls, rc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            mr[i] = 0;
        end
        msp = '0; mvalid = 1'b0; mstep = 0;
    endtask

    // One clock: drive at negedge, check ready, step model, check outputs after the edge.
    task automatic step(input bit vld, input bit rdy, input bit clr, input bit chk);
        bit exp_ready, acc;
        int leak, nv;
        in_valid = vld; spikes_ready = rdy; clear = clr;
        threshold = W'(thr); leak_shift = 3'(ls); refrac_cycles = 4'(rc);
        for (int i = 0; i < N; i++) currents[i] = W'(cur[i]);
        #1;
        exp_ready = !mvalid || rdy || clr;
        if (chk) check("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = vld && exp_ready && !clr;
        if (clr) begin
            model_reset();
        end else if (acc) begin
            for (int i = 0; i < N; i++) begin
                if (mr[i] > 0) begin
                    mr[i] = mr[i] - 1; mv[i] = 0; msp[i] = 1'b0;
                end else begin
                    leak = (ls == 0) ? 0 : (mv[i] >>> ls);
                    nv = mv[i] - leak + cur[i];
                    if (nv > 127) nv = 127;
                    if (nv < -128) nv = -128;
                    if (nv >= thr) begin
                        msp[i] = 1'b1; mv[i] = 0; mr[i] = rc;
                    end else begin
                        msp[i] = 1'b0; mv[i] = nv;
                    end
                end
            end
            mvalid = 1'b1;
            mstep = (mstep + 1) % 65536;
        end else if (rdy) begin
            mvalid = 1'b0;
        end
        @(posedge clk); #1;
        if (chk) begin
            check("spikes_valid", 32'(spikes_valid), 32'(mvalid));
            check("spikes", 32'(spikes), 32'(msp));
            check("step_count", 32'(step_count), 32'(mstep));
        end
        @(negedge clk);
    endtask

    task automatic set_cur0(input int c0);
        for (int i = 0; i < N; i++) cur[i] = 0;
        cur[0] = c0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; spikes_ready = 1'b0; clear = 1'b0;
        currents = '0; threshold = '0; leak_shift = '0; refrac_cycles = '0;
        thr = 20; ls = 0; rc = 2;
        set_cur0(0);
        model_reset();
        #1;
        check("rst_spikes_valid", 32'(spikes_valid), 32'd0);
        check("rst_spikes", 32'(spikes), 32'd0);
        check("rst_step_count", 32'(step_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Integrate and fire: 7,7,7 against threshold 20
        set_cur0(7);
        step(1, 1, 0, 1); check("if_s1", 32'(spikes[0]), 32'd0);
        step(1, 1, 0, 1); check("if_s2", 32'(spikes[0]), 32'd0);
        step(1, 1, 0, 1); check("if_s3", 32'(spikes[0]), 32'd1);
        check("if_steps", 32'(step_count), 32'd3);
        // Membrane restarted from zero: 7 alone must not fire
        step(1, 1, 0, 1); check("if_v0", 32'(spikes[0]), 32'd0);
        step(0, 1, 1, 1);

        // Refractory: 25 for five steps -> 1,0,0,1,0
        set_cur0(25);
        step(1, 1, 0, 1); check("refr_1", 32'(spikes[0]), 32'd1);
        step(1, 1, 0, 1); check("refr_2", 32'(spikes[0]), 32'd0);
        step(1, 1, 0, 1); check("refr_3", 32'(spikes[0]), 32'd0);
        step(1, 1, 0, 1); check("refr_4", 32'(spikes[0]), 32'd1);
        step(1, 1, 0, 1); check("refr_5", 32'(spikes[0]), 32'd0);
        step(0, 1, 1, 1);

        // Refractory disabled: consecutive firing
        rc = 0;
        step(1, 1, 0, 1); check("rc0_1", 32'(spikes[0]), 32'd1);
        step(1, 1, 0, 1); check("rc0_2", 32'(spikes[0]), 32'd1);
        rc = 2;
        step(0, 1, 1, 1);

        // Saturation: 120 + 100 clamps to 127 and meets threshold 127
        thr = 127;
        set_cur0(120); step(1, 1, 0, 1); check("sat_pre", 32'(spikes[0]), 32'd0);
        set_cur0(100); step(1, 1, 0, 1); check("sat_fire", 32'(spikes[0]), 32'd1);
        step(0, 1, 1, 1);
        // Negative saturation then recovery
        thr = 20;
        set_cur0(-128); step(1, 1, 0, 1); step(1, 1, 0, 1);
        set_cur0(127); step(1, 1, 0, 1); check("sat_neg", 32'(spikes[0]), 32'd0);
        step(0, 1, 1, 1);

        // Leak: v=40, shift 1, current 0 -> 20, fires at threshold 20
        thr = 50; ls = 1;
        set_cur0(40); step(1, 1, 0, 1); check("leak_pre", 32'(spikes[0]), 32'd0);
        thr = 20;
        set_cur0(0); step(1, 1, 0, 1); check("leak_fire", 32'(spikes[0]), 32'd1);
        ls = 0;
        step(0, 1, 1, 1);

        // Backpressure then simultaneous consume and accept
        set_cur0(25);
        step(1, 1, 0, 1);
        step(1, 0, 0, 1); check("bp_ready", 32'(in_ready), 32'd0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1); check("bp_steps", 32'(step_count), 32'd1);
        step(1, 1, 0, 1); check("bp_valid", 32'(spikes_valid), 32'd1);
        check("bp_steps2", 32'(step_count), 32'd2);
        step(0, 1, 0, 1);

        // Clear beats accept
        step(1, 1, 0, 1);
        step(1, 1, 1, 1);
        check("clr_steps", 32'(step_count), 32'd0);
        check("clr_valid", 32'(spikes_valid), 32'd0);

        // Reset mid-operation discards pending spikes
        set_cur0(25);
        step(1, 1, 0, 1);
        step(0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid", 32'(spikes_valid), 32'd0);
        check("arst_spikes", 32'(spikes), 32'd0);
        check("arst_steps", 32'(step_count), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 1); check("arst_resume", 32'(spikes[0]), 32'd1);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(15) == 0) begin
                thr = int'($urandom_range(120)) - 20;
                ls  = int'($urandom_range(7));
                rc  = int'($urandom_range(3));
            end
            for (int i = 0; i < N; i++) cur[i] = int'($urandom_range(255)) - 128;
            step(bit'($urandom_range(3) != 0), bit'($urandom_range(2) != 0),
                 bit'($urandom_range(39) == 0), 1);
        end

        // Counter wrap
        step(0, 1, 1, 1);
        set_cur0(0);
        for (int k = 0; k < 65534; k++) step(1, 1, 0, 0);
        step(1, 1, 0, 1); check("wrap_ffff", 32'(step_count), 32'hFFFF);
        step(1, 1, 0, 1); check("wrap_zero", 32'(step_count), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lif_spike_gen.md
LIF_SPIKE_GEN -- requirements
Module: lif_spike_gen

Interface
REQ-001 SHALL use parameter OUTPUT_VEC_LEN, default from DPE_params, number of neurons (one per MAC output lane).
REQ-002 SHALL use parameter WIDTH, default from DPE_params, width of each MAC output and of the membrane potential.
REQ-003 SHALL use parameter REFRAC_W, default 4, width of the refractory counter and its load value.
REQ-004 SHALL use parameter LEAK_W, default 3, width of the leak shift amount.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports listed below.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  the currents vector is valid this cycle.
REQ-009 in_ready  output  1  the block accepts currents this cycle.
REQ-010 currents  input  [OUTPUT_VEC_LEN-1:0][WIDTH-1:0]  signed two's-complement MAC outputs, one per neuron.
REQ-011 threshold  input  WIDTH  signed firing threshold, quasi-static.
REQ-012 leak_shift  input  LEAK_W  leak = v >>> leak_shift; a value of 0 disables leak.
REQ-013 refrac_cycles  input  REFRAC_W  accepted timesteps a neuron is held silent after firing.
REQ-014 clear  input  1  synchronous clear of all membranes and refractory counters.
REQ-015 spikes  output  [OUTPUT_VEC_LEN-1:0]  spike vector for the next layer's spike input.
REQ-016 spikes_valid  output  1  spikes holds a new timestep result.
REQ-017 spikes_ready  input  1  downstream consumes spikes this cycle.
REQ-018 step_count  output  16  number of timesteps accepted since reset or clear; wraps from 0xFFFF to 0.

Function
REQ-019 SHALL drive in_ready = ~spikes_valid | spikes_ready; an input is accepted when in_valid & in_ready.
REQ-020 On acceptance, each neuron i SHALL update as follows. If refrac[i] != 0: refrac[i] decrements, v[i] stays 0, spike[i] = 0, and currents[i] is ignored. Otherwise v_next = v[i] - (v[i] >>> leak_shift) + currents[i].
REQ-021 v_next SHALL be computed in WIDTH+2 bits and saturated to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-022 If saturated v_next >= threshold (signed compare): spike[i] = 1, v[i] = 0, refrac[i] = refrac_cycles. Otherwise spike[i] = 0 and v[i] = v_next.
REQ-023 The spikes vector and spikes_valid SHALL be registered; spikes_valid rises on the cycle after acceptance (latency 1).
REQ-024 spikes SHALL hold stable while spikes_valid & ~spikes_ready.
REQ-025 spikes_valid SHALL clear after a handshake unless a new input is accepted in the same cycle. Simultaneous consume and accept gives back-to-back valid output at full throughput.
REQ-026 Membrane state SHALL change only on acceptance; a stalled cycle leaves v, refrac and step_count unchanged.
REQ-027 step_count SHALL increment by 1 per acceptance and wrap from 0xFFFF to 0.
REQ-028 clear SHALL zero all v, refrac, step_count, spikes and spikes_valid on the next edge, and SHALL take priority over a same-cycle acceptance, which is dropped.
REQ-029 in_ready SHALL evaluate to 1 while clear is asserted.
REQ-030 refrac_cycles = 0 SHALL allow a neuron to fire on consecutive timesteps.

Reset
REQ-031 While rst_n = 0: all v = 0, refrac = 0, spikes = 0, spikes_valid = 0, step_count = 0; in_ready then evaluates to 1.
REQ-032 A reset asserted mid-operation SHALL discard any pending undelivered spikes; operation resumes on the first edge after rst_n deasserts.

Structure
REQ-033 WIDTH and OUTPUT_VEC_LEN SHALL come from DPE_params; REFRAC_W and LEAK_W SHALL be added to DPE_params.
REQ-034 One sub-module, lif_neuron, SHALL hold v, refrac and the update/saturate/compare logic. It SHALL be instantiated OUTPUT_VEC_LEN times by generate.
REQ-035 The top level SHALL hold only the handshake, output register and step_count.

Verification (WIDTH=8, threshold=20, leak_shift=0, refrac_cycles=2 unless stated)
REQ-036 Integrate and fire: currents[0] = 7 on steps 1, 2 and 3 (with spikes_ready=1) -> spike[0] = 0, 0, 1; v[0] = 0 after step 3; step_count = 3.
REQ-037 Refractory: currents[0] = 25 for 5 steps -> spike[0] = 1, 0, 0, 1, 0.
REQ-038 Saturation and leak: v = 120 with current 100 -> v = 127; with leak_shift=1, v = 40 and current 0 -> v = 20 and a spike when threshold = 20.
REQ-039 Backpressure: spikes_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, spikes stable, step_count +1 only. Then spikes_ready = 1 for one cycle with in_valid = 1 -> a handshake and a simultaneous accept occur, and spikes_valid stays 1.
REQ-040 Clear/reset priority: clear asserted together with an accept -> step_count = 0, spikes_valid = 0 on the next cycle. rst_n pulsed low while spikes_valid = 1 -> all outputs 0 immediately.
REQ-041 Wrap: preload 0xFFFF accepts -> step_count wraps to 0x0000 on the next accept.
